// File: rtl/mmio_debug_pkg.sv
// Shared constants for the MMIO debug port: register offsets within the 16-byte window,
// STATUS bit positions and the window decode helper.
package mmio_debug_pkg;

  // Register select values, taken from addr[3:2]
  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_HALT   = 2'd2;
  localparam logic [1:0] OFF_CYCLE  = 2'd3;

  // STATUS register layout
  localparam int unsigned STATUS_FULL_BIT   = 0;
  localparam int unsigned STATUS_EMPTY_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT    = 2;
  localparam int unsigned STATUS_HALTED_BIT = 3;
  localparam int unsigned STATUS_COUNT_LSB  = 8;
  localparam int unsigned STATUS_COUNT_W    = 8;

  // True when addr falls inside the 16-byte window starting at base
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/mmio_debug_port_if.sv
// CPU data-bus and console-sink signals of the MMIO debug port.
//   wr_en/rd_en/addr/wdata : CPU store/load request
//   rdata                  : combinational load data
//   tx_valid/tx_data/tx_ready : console sink handshake
//   halted/exit_code/done  : program-completion status
// master: CPU/bench side, slave: peripheral side.
interface mmio_debug_port_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic [7:0]  exit_code;
  logic        done;

  modport master (
    output wr_en, rd_en, addr, wdata, tx_ready,
    input  rdata, tx_valid, tx_data, halted, exit_code, done
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata, tx_ready,
    output rdata, tx_valid, tx_data, halted, exit_code, done
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy counter.
//   push_i/din_i/full_o  : write side; a push while full is ignored unless popping too
//   pop_i/dout_o/empty_o : read side; dout_o is the head entry, pop while empty is ignored
//   count_o              : current number of entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same edge, so a full FIFO may still accept
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is reset so the head output reads zero after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_debug_port.sv
// Memory-mapped debug peripheral on the CPU data bus. Decodes a 16-byte window:
//   +0x0 TX     : store pushes wdata[7:0] to the console FIFO, load returns 0
//   +0x4 STATUS : {count[15:8], halted, overflow, empty, full}; any store clears overflow
//   +0x8 HALT   : first store sets halted and latches exit_code, load returns exit_code
//   +0xC CYCLE  : free-running cycle counter, frozen once halted
// Ports: clk_i, rst_ni (async active-low), bus_io (CPU bus + console sink + status).
// rdata and done are combinational; all other outputs come from registers.
module mmio_debug_port
  import mmio_debug_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CYCLE_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mmio_debug_port_if.slave   bus_io
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic               hit, wr_hit;
  logic [1:0]         sel;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_head;
  logic [CntW-1:0]    fifo_count;
  logic               overflow_q, overflow_d;
  logic               halted_q, halted_d;
  logic [7:0]         exit_code_q, exit_code_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign hit    = addr_hit(bus_io.addr, BASE_ADDR);
  assign sel    = bus_io.addr[3:2];
  assign wr_hit = bus_io.wr_en && hit;

  assign unused_bits = ^{bus_io.addr[1:0], bus_io.wdata[31:8]};

  assign fifo_pop  = !fifo_empty && bus_io.tx_ready;
  assign fifo_push = wr_hit && (sel == OFF_TX) && (!fifo_full || fifo_pop) && !halted_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .din_i   (bus_io.wdata[7:0]),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    overflow_d  = overflow_q;
    halted_d    = halted_q;
    exit_code_d = exit_code_q;
    if (wr_hit && (sel == OFF_STATUS)) begin
      overflow_d = 1'b0;
    end else if (wr_hit && (sel == OFF_TX) && fifo_full && !fifo_pop && !halted_q) begin
      // Dropped byte; stores after halt are discarded silently instead
      overflow_d = 1'b1;
    end
    if (wr_hit && (sel == OFF_HALT) && !halted_q) begin
      halted_d    = 1'b1;
      exit_code_d = bus_io.wdata[7:0];
    end
    cycle_d = halted_q ? cycle_q : cycle_q + CYCLE_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
      exit_code_q <= '0;
      cycle_q     <= '0;
    end else begin
      overflow_q  <= overflow_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
      cycle_q     <= cycle_d;
    end
  end

  always_comb begin
    status_word                                      = '0;
    status_word[STATUS_FULL_BIT]                     = fifo_full;
    status_word[STATUS_EMPTY_BIT]                    = fifo_empty;
    status_word[STATUS_OVF_BIT]                      = overflow_q;
    status_word[STATUS_HALTED_BIT]                   = halted_q;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W]  = STATUS_COUNT_W'(fifo_count);
  end

  // Loads see pre-edge state, so a same-cycle store is not visible yet
  always_comb begin
    bus_io.rdata = '0;
    if (bus_io.rd_en && hit) begin
      unique case (sel)
        OFF_TX:     bus_io.rdata = '0;
        OFF_STATUS: bus_io.rdata = status_word;
        OFF_HALT:   bus_io.rdata = {24'b0, exit_code_q};
        OFF_CYCLE:  bus_io.rdata = 32'(cycle_q);
      endcase
    end
  end

  assign bus_io.tx_valid  = !fifo_empty;
  assign bus_io.tx_data   = fifo_head;
  assign bus_io.halted    = halted_q;
  assign bus_io.exit_code = exit_code_q;
  assign bus_io.done      = halted_q && fifo_empty;

endmodule

// File: tb/tb_mmio_debug_port.sv
// Self-checking bench for mmio_debug_port: a register-access vector table plus
// hand-written sequences; console bytes are checked against a scoreboard queue.
module tb_mmio_debug_port;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  mmio_debug_port_if bus ();

  mmio_debug_port #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .CYCLE_W    (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  logic        rdy = 1'b0;
  logic [31:0] rd;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic        push;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus cycle: inputs change on the falling edge, sampled 1ns later
  task automatic drive(input logic wr, input logic rd_e, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    bus.wr_en    = wr;
    bus.rd_en    = rd_e;
    bus.addr     = a;
    bus.wdata    = d;
    bus.tx_ready = rdy;
    #1;
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    drive(1'b0, 1'b1, a, 32'h0);
    d = bus.rdata;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d);
    drive(1'b1, 1'b1, a, wd);
    d = bus.rdata;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.tx_ready = 1'b0;
    rdy = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic drain(input string nm);
    rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      bus_idle();
    end
    bus_idle();
    bus_idle();
    check({nm, "_left"}, 32'(exp_q.size()), 32'h0);
    check({nm, "_valid"}, {31'b0, bus.tx_valid}, 32'h0);
    rdy = 1'b0;
  endtask

  // Sink monitor: every accepted byte must match the scoreboard head
  always @(negedge clk) begin
    #2;
    if (rst_ni && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%02h expected no byte", bus.tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {24'b0, bus.tx_data}, {24'b0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.tx_ready = 1'b0;

    // Reset held for 3 cycles
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    check("rst_halted", {31'b0, bus.halted}, 32'h0);
    check("rst_exit_code", {24'b0, bus.exit_code}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    @(negedge clk) rst_ni = 1'b1;

    // Register-access table, sink stalled
    vecs[0]  = '{1'b0, 1'b1, BASE + 32'h4,  32'h0,  1'b1, 32'h0000_0002, 1'b0, "status_reset"};
    vecs[1]  = '{1'b0, 1'b1, BASE + 32'h7,  32'h0,  1'b1, 32'h0000_0002, 1'b0, "status_low_bits"};
    vecs[2]  = '{1'b0, 1'b1, BASE + 32'h0,  32'h0,  1'b1, 32'h0000_0000, 1'b0, "tx_reads_zero"};
    vecs[3]  = '{1'b0, 1'b1, BASE + 32'h8,  32'h0,  1'b1, 32'h0000_0000, 1'b0, "halt_reset"};
    vecs[4]  = '{1'b0, 1'b1, BASE - 32'h4,  32'h0,  1'b1, 32'h0000_0000, 1'b0, "miss_below"};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h10, 32'h55, 1'b0, 32'h0000_0000, 1'b0, "miss_store"};
    vecs[6]  = '{1'b0, 1'b1, BASE + 32'h4,  32'h0,  1'b1, 32'h0000_0002, 1'b0, "status_after_miss"};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h14, 32'h0,  1'b1, 32'h0000_0000, 1'b0, "miss_above"};
    vecs[8]  = '{1'b1, 1'b0, BASE + 32'h3,  32'hA5, 1'b0, 32'h0000_0000, 1'b1, "tx_store_a11"};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h4,  32'h0,  1'b1, 32'h0000_0100, 1'b0, "status_count1"};
    vecs[10] = '{1'b1, 1'b0, BASE + 32'h0,  32'h3C, 1'b0, 32'h0000_0000, 1'b1, "tx_store"};
    vecs[11] = '{1'b0, 1'b1, BASE + 32'h6,  32'h0,  1'b1, 32'h0000_0200, 1'b0, "status_count2"};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check(vecs[i].name, bus.rdata, vecs[i].exp_rd);
      if (vecs[i].push) exp_q.push_back(vecs[i].wdata[7:0]);
    end
    drain("drain_table");

    // Two stores with the sink ready: head shows one cycle after each store
    rdy = 1'b1;
    bus_wr(BASE, 32'h48);
    exp_q.push_back(8'h48);
    @(posedge clk); #1;
    check("hello_valid0", {31'b0, bus.tx_valid}, 32'h1);
    check("hello_data0", {24'b0, bus.tx_data}, 32'h48);
    bus_wr(BASE, 32'h69);
    exp_q.push_back(8'h69);
    @(posedge clk); #1;
    check("hello_valid1", {31'b0, bus.tx_valid}, 32'h1);
    check("hello_data1", {24'b0, bus.tx_data}, 32'h69);
    bus_idle();
    @(posedge clk); #1;
    check("hello_empty", {31'b0, bus.tx_valid}, 32'h0);
    rdy = 1'b0;

    // Reset between edges while bytes are queued
    bus_wr(BASE, 32'h11);
    bus_wr(BASE, 32'h22);
    bus_idle();
    check("pre_reset_head", {24'b0, bus.tx_data}, 32'h11);
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    check("async_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    check("async_tx_data", {24'b0, bus.tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    rdy = 1'b1;
    repeat (5) bus_idle();
    check("post_reset_empty", {31'b0, bus.tx_valid}, 32'h0);
    rdy = 1'b0;

    // Overflow: 17 stores into a 16-entry FIFO with the sink stalled
    for (int i = 1; i <= 17; i++) begin
      bus_wr(BASE, 32'(i));
      if (i <= 16) exp_q.push_back(8'(i));
    end
    bus_rw(BASE + 32'h4, 32'h0, rd);
    check("ovf_status", rd, 32'h0000_1005);
    bus_rd(BASE + 32'h4, rd);
    check("ovf_cleared", rd, 32'h0000_1001);
    // Push and pop in the same cycle while full
    rdy = 1'b1;
    bus_wr(BASE, 32'hEE);
    exp_q.push_back(8'hEE);
    bus_rd(BASE + 32'h4, rd);
    check("full_push_pop", rd, 32'h0000_1001);
    drain("drain_ovf");

    // HALT after 100 cycles out of reset
    do_reset();
    repeat (100) bus_idle();
    bus_rd(BASE + 32'hC, rd);
    check("cycle_101", rd, 32'd101);
    bus_wr(BASE, 32'h77);
    exp_q.push_back(8'h77);
    bus_wr(BASE + 32'h8, 32'hFFFF_FF2A);
    bus_rd(BASE + 32'hC, rd);
    check("cycle_at_halt", rd, 32'd104);
    check("halted_set", {31'b0, bus.halted}, 32'h1);
    check("exit_code", {24'b0, bus.exit_code}, 32'h2A);
    check("done_wait_fifo", {31'b0, bus.done}, 32'h0);
    bus_wr(BASE + 32'h8, 32'h55);
    bus_wr(BASE, 32'h99);
    bus_rd(BASE + 32'h8, rd);
    check("halt_readback", rd, 32'h0000_002A);
    bus_rd(BASE + 32'h4, rd);
    check("status_halted", rd, 32'h0000_0108);
    bus_rd(BASE + 32'hC, rd);
    check("cycle_frozen", rd, 32'd104);
    drain("drain_halt");
    check("done_set", {31'b0, bus.done}, 32'h1);
    bus_rd(BASE + 32'h4, rd);
    check("status_done", rd, 32'h0000_000A);

    // Asynchronous reset clears halt state without an edge
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    check("async_halted", {31'b0, bus.halted}, 32'h0);
    check("async_exit_code", {24'b0, bus.exit_code}, 32'h0);
    check("async_done", {31'b0, bus.done}, 32'h0);
    @(negedge clk) rst_ni = 1'b1;
    bus_rd(BASE + 32'h4, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
